// File: rtl/vi_rst_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// legal parameter ranges and the counter-width helper.
package vi_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } rst_state_e;

    localparam int unsigned NCH_MIN   = 1;
    localparam int unsigned NCH_MAX   = 16;
    localparam int unsigned SYNC_MIN  = 2;
    localparam int unsigned SYNC_MAX  = 4;
    localparam int unsigned HOLD_MIN  = 1;
    localparam int unsigned HOLD_MAX  = 65535;
    localparam int unsigned GAP_MAX   = 255;
    localparam logic [7:0]  RST_CNT_MAX = 8'hFF;

    // Bits needed to hold the value n (at least one).
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((n >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/vi_sync_stages.sv
// Single-bit multi-flop synchronizer; resets to 0 so a channel reads as
// "request active" until its input has propagated through.
module vi_sync_stages #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/vi_rst_seq.sv
// Reset sequencer: holds all domains in reset until requests have been idle
// for HOLD_CYCLES, then releases them one by one in ascending order.
module vi_rst_seq
    import vi_rst_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic [NCH-1:0] iRST_REQ_N,
    input  logic           iSW_RST,
    input  logic           iCAUSE_CLR,
    output logic [NCH-1:0] oRST_N,
    output logic           oBUSY,
    output logic           oDONE,
    output logic [NCH:0]   oCAUSE,
    output logic [7:0]     oRST_CNT
);

    localparam int unsigned HW = cnt_width(HOLD_CYCLES);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);
    localparam int unsigned IW = cnt_width(NCH);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NCH - 1);

    logic [NCH-1:0] req_n_sync;
    logic           req_any;

    for (genvar g = 0; g < NCH; g++) begin : g_sync
        vi_sync_stages #(
            .DEPTH (SYNC_STAGES)
        ) u_sync (
            .clk_i (iCLK),
            .rst_i (iRST),
            .d_i   (iRST_REQ_N[g]),
            .q_o   (req_n_sync[g])
        );
    end

    assign req_any = (|(~req_n_sync)) | iSW_RST;

    rst_state_e     state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] rst_n_q, rst_n_d;
    logic [NCH:0]   cause_q, cause_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           busy_q, done_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        cnt_d   = cnt_q;

        if (req_any) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            gap_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
            if (state_q != ST_HOLD && cnt_q != RST_CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        rst_n_d[0] = 1'b1;
                        gap_d      = '0;
                        idx_d      = IW'(1);
                        state_d    = (NCH == 1) ? ST_RUN : ST_STAGGER;
                    end
                end
                ST_STAGGER: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        for (int unsigned i = 0; i < NCH; i++) begin
                            if (idx_q == IW'(i)) rst_n_d[i] = 1'b1;
                        end
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) state_d = ST_RUN;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                ST_RUN:  ;
                default: state_d = ST_HOLD;
            endcase
        end

        // A source active this cycle is recorded even if a clear arrives with it.
        cause_d = (iCAUSE_CLR ? '0 : cause_q) | {iSW_RST, ~req_n_sync};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            busy_q  <= ~(&rst_n_d);
            done_q  <= (state_d == ST_RUN);
        end
    end

    assign oRST_N   = rst_n_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign oCAUSE   = cause_q;
    assign oRST_CNT = cnt_q;

endmodule

// File: tb/tb_vi_rst_seq.sv
// Directed bench for vi_rst_seq: default build plus GAP_CYCLES=0 and NCH=1
// builds sharing the same clock and stimulus.
module tb_vi_rst_seq;

    logic       clk;
    logic       rst;
    logic [3:0] req_n;
    logic       sw;
    logic       clr;

    logic [3:0] rst_n;
    logic       busy, done;
    logic [4:0] cause;
    logic [7:0] cnt;

    logic [3:0] g0_rst_n;
    logic       g0_busy, g0_done;
    logic [4:0] g0_cause;
    logic [7:0] g0_cnt;

    logic [0:0] n1_rst_n;
    logic       n1_busy, n1_done;
    logic [1:0] n1_cause;
    logic [7:0] n1_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    vi_rst_seq dut (
        .iCLK(clk), .iRST(rst), .iRST_REQ_N(req_n), .iSW_RST(sw), .iCAUSE_CLR(clr),
        .oRST_N(rst_n), .oBUSY(busy), .oDONE(done), .oCAUSE(cause), .oRST_CNT(cnt)
    );

    vi_rst_seq #(.GAP_CYCLES(0)) dut_g0 (
        .iCLK(clk), .iRST(rst), .iRST_REQ_N(req_n), .iSW_RST(sw), .iCAUSE_CLR(clr),
        .oRST_N(g0_rst_n), .oBUSY(g0_busy), .oDONE(g0_done), .oCAUSE(g0_cause),
        .oRST_CNT(g0_cnt)
    );

    vi_rst_seq #(.NCH(1), .GAP_CYCLES(0)) dut_n1 (
        .iCLK(clk), .iRST(rst), .iRST_REQ_N(req_n[0]), .iSW_RST(sw), .iCAUSE_CLR(clr),
        .oRST_N(n1_rst_n), .oBUSY(n1_busy), .oDONE(n1_done), .oCAUSE(n1_cause),
        .oRST_CNT(n1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Steps first+15 edges; bit0 releases at edge `first`, then every 5 edges.
    task automatic check_seq(input int first, input bit ext);
        logic [3:0] exp, exp_g0;
        for (int k = 1; k <= first + 15; k++) begin
            tick();
            exp = {k >= first + 15, k >= first + 10, k >= first + 5, k >= first};
            chk("rst_n", 32'(rst_n), 32'(exp));
            chk("busy", 32'(busy), 32'(exp != 4'hF));
            chk("done", 32'(done), 32'(k >= first + 15));
            if (ext) begin
                exp_g0 = {k >= first + 3, k >= first + 2, k >= first + 1, k >= first};
                chk("g0_rst_n", 32'(g0_rst_n), 32'(exp_g0));
                chk("g0_done", 32'(g0_done), 32'(k >= first + 3));
                chk("n1_rst_n", 32'(n1_rst_n), 32'(k >= first));
                chk("n1_done", 32'(n1_done), 32'(k >= first));
                chk("n1_busy", 32'(n1_busy), 32'(k < first));
            end
        end
    endtask

    task automatic pulse_req(input int ch);
        req_n[ch] = 1'b0;
        tick();
        req_n = 4'hF;
    endtask

    initial begin
        rst = 1'b1; req_n = 4'hF; sw = 1'b0; clr = 1'b0;
        repeat (3) tick();
        chk("rst_rst_n", 32'(rst_n), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cause", 32'(cause), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);

        // Startup: sync flops read as active for SYNC_STAGES cycles
        rst = 1'b0;
        check_seq(19, 1'b1);
        chk("start_cause", 32'(cause), 32'h0F);
        chk("start_cnt", 32'(cnt), 32'h0);
        chk("n1_cause", 32'(n1_cause), 32'h1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_cause", 32'(cause), 32'h0);

        // One-cycle request on channel 2 from RUN
        pulse_req(2);
        tick(); tick();
        chk("req2_lat_early", 32'(rst_n), 32'hF);
        tick();
        chk("req2_rst_n", 32'(rst_n), 32'h0);
        chk("req2_busy", 32'(busy), 32'h1);
        chk("req2_done", 32'(done), 32'h0);
        chk("req2_cause", 32'(cause), 32'h04);
        chk("req2_cnt", 32'(cnt), 32'h1);
        check_seq(16, 1'b0);

        // Request re-asserted while the hold counter sits at 10
        pulse_req(1);
        tick(); tick(); tick();
        chk("req1_rst_n", 32'(rst_n), 32'h0);
        chk("req1_cnt", 32'(cnt), 32'h2);
        repeat (7) tick();
        pulse_req(1);
        tick(); tick();
        chk("rehold_rst_n", 32'(rst_n), 32'h0);
        tick();
        chk("rehold_cnt", 32'(cnt), 32'h2);
        chk("rehold_cause", 32'(cause), 32'h06);
        check_seq(16, 1'b0);

        // Software reset from RUN, then again mid-STAGGER after bit 1
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr2_cause", 32'(cause), 32'h0);
        sw = 1'b1; tick(); sw = 1'b0;
        chk("sw_rst_n", 32'(rst_n), 32'h0);
        chk("sw_cause", 32'(cause), 32'h10);
        chk("sw_cnt", 32'(cnt), 32'h3);
        repeat (16) tick();
        chk("sw_bit0", 32'(rst_n), 32'h1);
        repeat (5) tick();
        chk("sw_bit1", 32'(rst_n), 32'h3);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr3_cause", 32'(cause), 32'h0);
        chk("clr3_rst_n", 32'(rst_n), 32'h3);
        sw = 1'b1; tick(); sw = 1'b0;
        chk("stag_sw_rst_n", 32'(rst_n), 32'h0);
        chk("stag_sw_cause", 32'(cause), 32'h10);
        chk("stag_sw_cnt", 32'(cnt), 32'h4);

        // Set beats clear in the same cycle; HOLD->HOLD not counted
        clr = 1'b1; sw = 1'b1; tick(); clr = 1'b0; sw = 1'b0;
        chk("clr_sw_cause", 32'(cause), 32'h10);
        chk("clr_sw_cnt", 32'(cnt), 32'h4);

        // Saturation: 296 more STAGGER->HOLD events, 300 total
        for (int i = 1; i <= 296; i++) begin
            repeat (16) tick();
            sw = 1'b1; tick(); sw = 1'b0;
            if (i == 250) chk("cnt_254", 32'(cnt), 32'd254);
        end
        chk("cnt_sat", 32'(cnt), 32'd255);
        chk("sat_rst_n", 32'(rst_n), 32'h0);

        // iRST mid-STAGGER
        repeat (21) tick();
        chk("pre_rst_rst_n", 32'(rst_n), 32'h3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_rst_n", 32'(rst_n), 32'h0);
        chk("mid_rst_cnt", 32'(cnt), 32'h0);
        chk("mid_rst_cause", 32'(cause), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h1);
        chk("mid_rst_done", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vi_rst_seq.md
VI_RST_SEQ -- requirements
Module: vi_rst_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of reset request channels and output reset domains (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 3, synchronizer depth per request input (2..4).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, minimum request-free cycles before first release (1..65535).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, extra idle cycles between successive channel releases (0..255).
REQ-005 SHALL have port iCLK, input, 1, the single clock for all state.
REQ-006 SHALL have port iRST, input, 1, reset that is synchronous to iCLK and active-high.
REQ-007 SHALL have port iRST_REQ_N, input, NCH, asynchronous per-channel reset requests, active-low.
REQ-008 SHALL have port iSW_RST, input, 1, synchronous software reset pulse, active-high.
REQ-009 SHALL have port iCAUSE_CLR, input, 1, synchronous clear of oCAUSE.
REQ-010 SHALL have port oRST_N, output, NCH, sequenced reset per domain, active-low, registered.
REQ-011 SHALL have port oBUSY, output, 1, high while any oRST_N bit is low.
REQ-012 SHALL have port oDONE, output, 1, high in RUN state only.
REQ-013 SHALL have port oCAUSE, output, NCH+1, sticky record of the reset sources; bit NCH = iSW_RST.
REQ-014 SHALL have port oRST_CNT, output, 8, saturating count of reset events.

Function
REQ-015 SHALL pass each iRST_REQ_N bit through SYNC_STAGES flops; req_any = OR of inverted synchronized bits, OR iSW_RST.
REQ-016 SHALL implement FSM states HOLD, STAGGER, RUN; any state with req_any=1 -> HOLD, hold counter=0, all oRST_N=0 at the next edge.
REQ-017 SHALL make the latency from iRST_REQ_N low to oRST_N all-low SYNC_STAGES+1 edges, and from iSW_RST to all-low 1 edge.
REQ-018 SHALL, in HOLD, increment the hold counter on each req_any=0 cycle and clear it on a req_any=1 cycle.
REQ-019 SHALL, in HOLD, set oRST_N[0]=1 and go to STAGGER with idx=1 at the edge where the counter reaches HOLD_CYCLES.
REQ-020 SHALL, in STAGGER, release oRST_N[idx] exactly GAP_CYCLES+1 edges after oRST_N[idx-1], with GAP_CYCLES=0 giving consecutive edges.
REQ-021 SHALL go STAGGER->RUN on the same edge that releases oRST_N[NCH-1]; when NCH=1, HOLD goes directly to RUN.
REQ-022 SHALL keep channels released in ascending index only; released bits stay high until the next req_any.
REQ-023 SHALL set oCAUSE bit per asserted source on any cycle with that source active, with set winning over a simultaneous iCAUSE_CLR.
REQ-024 SHALL increment oRST_CNT by 1 on each STAGGER/RUN->HOLD transition, saturating at 255; iRST entry is not counted.
REQ-025 SHALL keep oBUSY = NOT(AND of oRST_N) and oDONE = (state==RUN), both registered and consistent with oRST_N in the same cycle.
REQ-026 SHALL ignore iCAUSE_CLR for all behaviour other than oCAUSE.

Reset
REQ-027 SHALL, on iRST=1 at an edge, force state=HOLD, counters=0, sync flops=0 (request active), oRST_N=0, oBUSY=1, oDONE=0, oCAUSE=0, oRST_CNT=0.
REQ-028 SHALL give iRST priority over all other inputs; a mid-STAGGER iRST returns all released channels to 0 on the next edge.

Structure
REQ-029 SHALL take the state enum, parameter limit constants and counter-width function from shared package vi_rst_pkg.
REQ-030 SHALL instantiate sub-module vi_sync_stages (parametrised depth, 1 bit) once per channel.

Verification
REQ-031 SHALL cover: defaults, iRST released, all iRST_REQ_N=1 -> oRST_N[0] rises at edge SYNC_STAGES+16, then bits 1,2,3 every 5 edges, oDONE=1 with bit 3.
REQ-032 SHALL cover: RUN, iRST_REQ_N[2]=0 for 1 cycle -> all oRST_N=0 4 edges later, oCAUSE=0b00100, oRST_CNT=1, full re-sequence.
REQ-033 SHALL cover: request re-asserted at hold count 10 -> counter restarts, oRST_N[0] rises 16 edges after the final clear.
REQ-034 SHALL cover: iSW_RST during STAGGER after bit 1 released -> all low next edge, oCAUSE[4]=1.
REQ-035 SHALL cover: iCAUSE_CLR and iSW_RST in the same cycle -> oCAUSE[4]=1; 300 events -> oRST_CNT=255.
REQ-036 SHALL cover: GAP_CYCLES=0, NCH=1 builds -> consecutive releases, and a direct HOLD->RUN transition.
